// File: rtl/shift_pkg.sv
// shift_pkg: mode encodings shared by the pipelined barrel shifter.
package shift_pkg;
    typedef enum logic [1:0] {
        MODE_SLL = 2'b00,
        MODE_SRA = 2'b01,
        MODE_SRL = 2'b10,
        MODE_ROR = 2'b11
    } mode_t;
endpackage

// File: rtl/shift_stage.sv
// shift_stage: combinational single-distance shift for all four modes.
module shift_stage
    import shift_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIST  = 1
) (
    input  logic             en_i,
    input  mode_t            mode_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);
    logic [DIST-1:0] fill;
    always_comb begin
        fill   = (mode_i == MODE_SRA) ? {DIST{data_i[WIDTH-1]}} :
                 (mode_i == MODE_ROR) ? data_i[DIST-1:0] : '0;
        data_o = !en_i                ? data_i :
                 (mode_i == MODE_SLL) ? {data_i[WIDTH-DIST-1:0], {DIST{1'b0}}} :
                                        {fill, data_i[WIDTH-1:DIST]};
    end
endmodule

// File: rtl/shift_pipe.sv
// shift_pipe: pipelined barrel shifter, one registered stage per shift-distance bit.
module shift_pipe
    import shift_pkg::*;
#(
    parameter  int WIDTH = 16,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_amt,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero
);
    logic             advance;
    logic [SHW-1:0]   vld_q, vld_d;
    logic [WIDTH-1:0] dat_q [SHW];
    logic [WIDTH-1:0] dat_d [SHW];
    logic [WIDTH-1:0] src_dat [SHW];
    mode_t            mode_q [SHW];
    mode_t            mode_d [SHW];
    logic [SHW-1:0]   amt_q [SHW];
    logic [SHW-1:0]   amt_d [SHW];
    logic             unused_tail;

    // Stage k sees its predecessor's register; stage 0 sees the input port.
    always_comb begin
        vld_d[0]   = in_valid;
        src_dat[0] = in_data;
        mode_d[0]  = mode_t'(in_mode);
        amt_d[0]   = in_amt;
        for (int k = 1; k < SHW; k++) begin
            vld_d[k]   = vld_q[k-1];
            src_dat[k] = dat_q[k-1];
            mode_d[k]  = mode_q[k-1];
            amt_d[k]   = amt_q[k-1];
        end
    end

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        shift_stage #(.WIDTH(WIDTH), .DIST(1 << k)) u_stage (
            .en_i   (amt_d[k][k]),
            .mode_i (mode_d[k]),
            .data_i (src_dat[k]),
            .data_o (dat_d[k])
        );
    end

    // Global advance: the whole pipe moves or the whole pipe holds.
    assign advance = out_ready | ~out_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int k = 0; k < SHW; k++) begin
                dat_q[k]  <= '0;
                mode_q[k] <= MODE_SLL;
                amt_q[k]  <= '0;
            end
        end else if (advance) begin
            vld_q  <= vld_d;
            dat_q  <= dat_d;
            mode_q <= mode_d;
            amt_q  <= amt_d;
        end
    end

    assign in_ready    = advance;
    assign out_valid   = vld_q[SHW-1];
    assign out_data    = dat_q[SHW-1];
    assign out_zero    = ~|out_data;
    assign unused_tail = ^{amt_q[SHW-1], mode_q[SHW-1]};
endmodule
